// File: rtl/gf163_pkg.sv
// ---------------------------------------------------------------------------
// gf163_pkg
// Shared definitions for GF(2^163) arithmetic with field polynomial
// f(x) = x^163 + x^7 + x^6 + x^3 + 1.
//   GF_M         field degree / operand width
//   GF_POLY      low-order taps of f(x) (x^163 term implicit)
//   INV_NUM_OPS  squarings + multiplications in one Fermat inversion
//   inv_state_t  inversion sequencer states
//   inv_op_t     operation issued to the shared multiplier
//   clmul82      82x82-bit carry-less product
//   gf_reduce    reduction of a 325-bit carry-less product modulo f(x)
// ---------------------------------------------------------------------------
package gf163_pkg;

    localparam int unsigned     GF_M        = 163;
    localparam logic [GF_M-1:0] GF_POLY     = 163'hC9;
    localparam int unsigned     INV_NUM_OPS = 323;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } inv_state_t;

    typedef enum logic {
        OP_SQ  = 1'b0,
        OP_MUL = 1'b1
    } inv_op_t;

    function automatic logic [162:0] clmul82(input logic [81:0] a, input logic [81:0] b);
        logic [162:0] p;
        p = '0;
        for (int unsigned i = 0; i < 82; i++) begin
            if (b[i]) begin
                p = p ^ ({81'b0, a} << i);
            end
        end
        return p;
    endfunction

    // Clears bits 324..163 from the top down; each set bit folds f(x)
    // shifted into place, so lower bits touched by the fold are handled later.
    function automatic logic [162:0] gf_reduce(input logic [324:0] p);
        logic [324:0] t;
        logic [324:0] f;
        int unsigned  idx;
        t = p;
        f = {161'b0, 1'b1, GF_POLY};
        for (int unsigned k = 0; k < 162; k++) begin
            idx = 324 - k;
            if (t[idx]) begin
                t = t ^ (f << (idx - 163));
            end
        end
        return t[162:0];
    endfunction

endpackage

// File: rtl/karatsuba_mult163_red.sv
// ---------------------------------------------------------------------------
// karatsuba_mult163_red
// Combinational GF(2^163) multiplier: one-level Karatsuba split (82/81 bits)
// followed by reduction modulo f(x).
//   i_a, i_b  operands, polynomial basis
//   o_c       i_a * i_b mod f(x)
// ---------------------------------------------------------------------------
module karatsuba_mult163_red
    import gf163_pkg::*;
(
    input  logic [GF_M-1:0] i_a,
    input  logic [GF_M-1:0] i_b,
    output logic [GF_M-1:0] o_c
);

    logic [81:0]  w_al, w_ah, w_bl, w_bh;
    logic [162:0] w_p0, w_p1, w_p2, w_mid;
    logic [324:0] w_full;

    assign w_al = i_a[81:0];
    assign w_ah = {1'b0, i_a[162:82]};
    assign w_bl = i_b[81:0];
    assign w_bh = {1'b0, i_b[162:82]};

    assign w_p0  = clmul82(w_al, w_bl);
    assign w_p2  = clmul82(w_ah, w_bh);
    assign w_p1  = clmul82(w_al ^ w_ah, w_bl ^ w_bh);
    assign w_mid = w_p1 ^ w_p0 ^ w_p2;

    assign w_full = {162'b0, w_p0}
                  ^ ({162'b0, w_mid} << 82)
                  ^ ({162'b0, w_p2}  << 164);

    assign o_c = gf_reduce(w_full);

endmodule

// File: rtl/gf163_inv_ctrl.sv
// ---------------------------------------------------------------------------
// gf163_inv_ctrl
// Fermat inversion a^-1 = a^(2^163-2) in GF(2^163), one shared multiplier
// operation per cycle: 161 x (square, multiply by a) then one final square.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (ready only in IDLE)
//   in_a                 element to invert
//   out_valid/out_ready  result handshake (valid only in DONE)
//   out_inv              a^-1 (0 for a = 0), zero outside DONE
//   busy                 high whenever not IDLE
// ---------------------------------------------------------------------------
module gf163_inv_ctrl
    import gf163_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [GF_M-1:0] in_a,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [GF_M-1:0] out_inv,
    output logic            busy
);

    localparam logic [8:0] LAST_OP = 9'(INV_NUM_OPS - 1);

    inv_state_t      r_state;
    inv_op_t         r_phase;
    logic [8:0]      r_cnt;
    logic [GF_M-1:0] r_a;
    logic [GF_M-1:0] r_r;
    logic [GF_M-1:0] w_opb;
    logic [GF_M-1:0] w_prod;

    assign w_opb = (r_phase == OP_MUL) ? r_a : r_r;

    karatsuba_mult163_red u_mult (
        .i_a (r_r),
        .i_b (w_opb),
        .o_c (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_phase <= OP_SQ;
            r_cnt   <= '0;
            r_a     <= '0;
            r_r     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_r     <= in_a;
                        r_cnt   <= '0;
                        r_phase <= OP_SQ;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_r     <= w_prod;
                    // Phase alternates every op; even counts (incl. the final 322) are squarings.
                    r_phase <= (r_phase == OP_SQ) ? OP_MUL : OP_SQ;
                    if (r_cnt == LAST_OP) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gated by rst so the block never advertises readiness while held in reset.
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign out_inv   = out_valid ? r_r : '0;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gf163_inv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gf163_inv_ctrl
// Self-checking bench for gf163_inv_ctrl. Reference arithmetic is a
// bit-serial shift-and-add GF(2^163) multiplier; random results are checked
// by a * a^-1 = 1, fixed vectors against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_gf163_inv_ctrl;
    import gf163_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [162:0] in_a;
    logic         out_valid;
    logic         out_ready;
    logic [162:0] out_inv;
    logic         busy;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    gf163_inv_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inv   (out_inv),
        .busy      (busy)
    );

    // Reference: multiply by x, reducing x^163 -> x^7 + x^6 + x^3 + 1.
    function automatic logic [162:0] ref_xtime(input logic [162:0] v);
        logic [162:0] s;
        s = v << 1;
        if (v[162]) s = s ^ 163'hC9;
        return s;
    endfunction

    function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
        logic [162:0] acc;
        acc = '0;
        for (int i = 162; i >= 0; i--) begin
            acc = ref_xtime(acc);
            if (b[i]) acc = acc ^ a;
        end
        return acc;
    endfunction

    function automatic logic [162:0] rand163();
        logic [191:0] w;
        logic [162:0] v;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        v = w[162:0];
        if (v == '0) v = 163'd1;
        return v;
    endfunction

    task automatic chk_bits(input string nm, input logic [162:0] act, input logic [162:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!in_ready && w < 1000) begin
            tick();
            w++;
        end
        chk_int("wait_in_ready", int'(in_ready), 1);
    endtask

    // Counts edges after the accept edge until out_valid is seen (-1 on timeout).
    task automatic wait_result(output logic [162:0] res, output int lat);
        lat = -1;
        res = '0;
        for (int k = 1; k <= 400; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                res = out_inv;
                break;
            end
        end
    endtask

    task automatic run_inv(input logic [162:0] a, output logic [162:0] res, output int lat);
        wait_ready();
        in_valid  = 1'b1;
        in_a      = a;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        wait_result(res, lat);
        tick();
    endtask

    typedef struct {
        logic [162:0] a;
        logic [162:0] exp;
    } vec_t;

    localparam logic [162:0] INV_X = (163'd1 << 162) | 163'h64;

    vec_t         tbl[4];
    logic [162:0] res, res2, a1, a2;
    int           lat, lat2;

    initial begin
        tbl[0] = '{a: 163'd1, exp: 163'd1};
        tbl[1] = '{a: 163'd2, exp: INV_X};
        tbl[2] = '{a: INV_X,  exp: 163'd2};
        tbl[3] = '{a: '0,     exp: '0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0;
        tick();
        chk_int("rst_in_ready", int'(in_ready), 0);
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk_int("rst_busy", int'(busy), 0);
        chk_bits("rst_out_inv", out_inv, '0);
        tick();
        rst = 1'b0;
        #1;
        chk_int("post_rst_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 4; i++) begin
            run_inv(tbl[i].a, res, lat);
            chk_bits($sformatf("vec%0d_inv", i), res, tbl[i].exp);
            chk_int($sformatf("vec%0d_latency", i), lat, 323);
            chk_int($sformatf("vec%0d_idle_after", i), int'(in_ready), 1);
        end

        // DONE held with out_ready low; new operands must be refused.
        wait_ready();
        in_valid = 1'b1; in_a = 163'd2; out_ready = 1'b0;
        tick();
        in_a = 163'd5;
        chk_int("hold_busy", int'(busy), 1);
        wait_result(res, lat);
        chk_int("hold_latency", lat, 323);
        for (int c = 0; c < 50; c++) begin
            chk_int("hold_out_valid", int'(out_valid), 1);
            chk_bits("hold_out_inv", out_inv, INV_X);
            chk_int("hold_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk_int("hold_release_in_ready", int'(in_ready), 1);
        chk_int("hold_release_out_valid", int'(out_valid), 0);

        // Reset during op 100.
        in_valid = 1'b1; in_a = rand163(); out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        chk_int("midrst_in_ready_low", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk_int("midrst_in_ready", int'(in_ready), 1);
        chk_int("midrst_out_valid", int'(out_valid), 0);
        chk_int("midrst_busy", int'(busy), 0);
        chk_bits("midrst_out_inv", out_inv, '0);
        run_inv(163'd1, res, lat);
        chk_bits("midrst_inv1", res, 163'd1);
        chk_int("midrst_latency", lat, 323);

        // Back-to-back with in_valid held high.
        a1 = rand163();
        a2 = rand163();
        wait_ready();
        in_valid = 1'b1; in_a = a1; out_ready = 1'b1;
        tick();
        in_a = a2;
        wait_result(res, lat);
        tick();
        chk_int("b2b_idle_in_ready", int'(in_ready), 1);
        chk_int("b2b_idle_busy", int'(busy), 0);
        tick();
        chk_int("b2b_second_accept_busy", int'(busy), 1);
        chk_int("b2b_second_accept_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        wait_result(res2, lat2);
        tick();
        chk_int("b2b_lat1", lat, 323);
        chk_int("b2b_lat2", lat2, 323);
        chk_bits("b2b_prod1", ref_mul(a1, res), 163'd1);
        chk_bits("b2b_prod2", ref_mul(a2, res2), 163'd1);

        // Random nonzero operands.
        for (int r = 0; r < 200; r++) begin
            a1 = rand163();
            run_inv(a1, res, lat);
            chk_bits($sformatf("rand%0d_prod", r), ref_mul(a1, res), 163'd1);
            chk_int($sformatf("rand%0d_latency", r), lat, 323);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
